stopwatch_display_scan: RTL and testbench
=========================================

// Module: stopwatch_display_scan
// PURPOSE
//  Downstream display stage for the stopwatch: takes the eight BCD digits the stopwatch counters produce and drives one multiplexed 8-digit 7-segment display.
//  Holds a tear-free per-frame snapshot of the digits, supports lap-freeze, blanks leading zeros and inserts separators.
//  Sits between the stopwatch counter chain and the board's segment/digit pins.
// PARAMETERS
//  SCAN_DIV        1000  clk_i cycles per digit slot (>= GUARD+2)
//  GUARD           2     cycles at start of each slot with all digits disabled (anti-ghosting)
//  SEG_ACTIVE_LOW  1     1: seg_o/dp_o lit = 0
//  DIG_ACTIVE_LOW  1     1: digit_sel_o enabled = 0
// PORTS
//  clk_i          in   1   single system clock
//  reset_i        in   1   synchronous, active-high reset
//  centisec_i     in   4   BCD digit 0 (rightmost)
//  decisec_i      in   4   BCD digit 1
//  sec_i          in   4   BCD digit 2
//  decasec_i      in   4   BCD digit 3
//  min_i          in   4   BCD digit 4
//  decamin_i      in   4   BCD digit 5
//  hr_i           in   4   BCD digit 6
//  decahr_i       in   4   BCD digit 7 (leftmost)
//  lap_i          in   1   lap button level, already debounced
//  seg_o          out  7   segments {g,f,e,d,c,b,a}
//  dp_o           out  1   decimal point of the active digit
//  digit_sel_o    out  8   one-hot digit enable, bit n = digit n
//  frame_o        out  1   1-cycle pulse, cycle after a snapshot load
//  lap_active_o   out  1   1 while the display is frozen
// BEHAVIOUR
//  Interface: one clock clk_i; reset_i is synchronous and active-high.
//  - Reset values: prescaler=0, slot index=0, snapshot=0, frozen=0, lap_prev=1.
//    Outputs at reset: seg_o, dp_o and digit_sel_o all inactive per their polarity; frame_o=0, lap_active_o=0.
//  - Reset asserted mid-frame: the same values apply on the next edge. No partial digit is shown.
//  - Prescaler counts 0..SCAN_DIV-1 and wraps. tick = (prescaler==SCAN_DIV-1).
//  - Slot index advances on tick: 0,1,..,7, then 7->0.
//  - Frame boundary = tick && index==7.
//  - Lap: rising edge of lap_i (lap_i && !lap_prev) toggles frozen. lap_active_o = frozen.
//    lap_prev resets to 1, so a button held through reset does not toggle.
//  - Snapshot (32 bit) loads all eight inputs at a frame boundary when frozen_next==0.
//    frozen_next is the value after this cycle's toggle:
//    -- a freeze edge in the boundary cycle suppresses the load;
//    -- an unfreeze edge in the boundary cycle allows it.
//  - frame_o pulses in the cycle after a load. There is no pulse while frozen.
//  - Leading-zero blanking uses the snapshot. Digit n (n in 7..3) is blank iff digits 7..n are all 0.
//    Digits 2..0 are never blank. Example: snapshot 00:00:05.07 displays "5.07".
//  - dp_o is lit on digits 2, 4 and 6 unless that digit is blank.
//  - Decoder: standard 0-9 patterns. Any code >9 shows "-" (g only).
//  - Output timing: all outputs are registered and reflect the slot index with 1-cycle latency.
//  - Guard window: for prescaler < GUARD, digit_sel_o is all inactive.
//    seg_o/dp_o already show the new digit during the guard.
//    For the remainder of the slot, exactly one digit_sel_o bit is active.
//  - Blank digit: digit_sel_o is active but seg_o and dp_o are inactive.
// STRUCTURE
//  - Shared header (stopwatch defines): 7-seg pattern constants (0-9, dash, off) and digit index constants DIG_CENTISEC..DIG_DECAHR.
//  - Sub-module bcd_to_seg7: combinational 4-bit BCD -> 7-bit active-high pattern. Invalid codes give the dash.
//  - Top level holds the prescaler, index, lap edge/toggle, snapshot, blank logic and output registers with polarity XOR.
// TESTING (SCAN_DIV=4, GUARD=1, both polarities active-low)
//  1. Reset held, then released with inputs 12:34:56.78.
//     -> digit_sel_o=8'hFF and seg_o=7'h7F during reset.
//     -> The first boundary loads the snapshot and frame_o pulses once.
//     -> The next frame scans digits 0..7 showing 8,7,6,5,4,3,2,1, with dp on digits 2, 4 and 6.
//  2. Snapshot 00:00:05.07.
//     -> Digits 7..3 are enabled but dark.
//     -> Digits 2..0 show 5,0,7 with dp on digit 2 only.
//  3. Inputs change mid-frame from 00:00:01.00 to 00:00:02.00.
//     -> The whole current frame shows 1.00.
//     -> The next frame shows 2.00. No mixed frame.
//  4. Lap edge while inputs count.
//     -> lap_active_o=1 and the display holds its value across 3+ frames with no frame_o.
//     -> A second edge clears lap_active_o and the next boundary loads live values.
//  5. Lap edge in the exact boundary cycle -> no load occurs.
//     decahr_i=4'hC -> digit 7 shows the dash.
//  6. Guard check: in every slot, digit_sel_o=8'hFF for exactly 1 cycle, then is one-hot-low for 3 cycles.
//     reset_i pulsed mid-slot -> all outputs inactive on the next cycle.

Source files
------------

// File: rtl/stopwatch_display_scan_pkg.sv
// Shared stopwatch display definitions: 7-segment patterns, digit indices
// and small helpers used by the display scanner.
package stopwatch_display_scan_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg7_t;   // {g,f,e,d,c,b,a}, active-high
  typedef logic [7:0] dig_sel_t;

  // Active-high segment patterns
  localparam seg7_t SEG7_0    = 7'h3F;
  localparam seg7_t SEG7_1    = 7'h06;
  localparam seg7_t SEG7_2    = 7'h5B;
  localparam seg7_t SEG7_3    = 7'h4F;
  localparam seg7_t SEG7_4    = 7'h66;
  localparam seg7_t SEG7_5    = 7'h6D;
  localparam seg7_t SEG7_6    = 7'h7D;
  localparam seg7_t SEG7_7    = 7'h07;
  localparam seg7_t SEG7_8    = 7'h7F;
  localparam seg7_t SEG7_9    = 7'h6F;
  localparam seg7_t SEG7_DASH = 7'h40;
  localparam seg7_t SEG7_OFF  = 7'h00;

  // Digit positions, rightmost first
  localparam int unsigned DIG_CENTISEC = 0;
  localparam int unsigned DIG_DECISEC  = 1;
  localparam int unsigned DIG_SEC      = 2;
  localparam int unsigned DIG_DECASEC  = 3;
  localparam int unsigned DIG_MIN      = 4;
  localparam int unsigned DIG_DECAMIN  = 5;
  localparam int unsigned DIG_HR       = 6;
  localparam int unsigned DIG_DECAHR   = 7;
  localparam int unsigned NUM_DIGITS   = 8;

  // Lowest digit position that may be blanked as a leading zero
  localparam int unsigned BLANK_LOW    = DIG_DECASEC;

  // One-hot active-high enable for a digit index
  function automatic dig_sel_t digit_onehot(input logic [2:0] idx);
    return dig_sel_t'(8'h01 << idx);
  endfunction

  // Digits that carry a separator dot after them (seconds, minutes, hours)
  function automatic logic has_dp(input logic [2:0] idx);
    return (idx == 3'(DIG_SEC)) || (idx == 3'(DIG_MIN)) || (idx == 3'(DIG_HR));
  endfunction

endpackage

// File: rtl/stopwatch_display_scan_if.sv
// Bundle of the display stage's digit inputs, lap button and pin outputs.
interface stopwatch_display_scan_if;
  import stopwatch_display_scan_pkg::*;

  bcd_t     centisec_i;
  bcd_t     decisec_i;
  bcd_t     sec_i;
  bcd_t     decasec_i;
  bcd_t     min_i;
  bcd_t     decamin_i;
  bcd_t     hr_i;
  bcd_t     decahr_i;
  logic     lap_i;
  seg7_t    seg_o;
  logic     dp_o;
  dig_sel_t digit_sel_o;
  logic     frame_o;
  logic     lap_active_o;

  // Side that produces the digits and consumes the display pins
  modport master (
    output centisec_i, decisec_i, sec_i, decasec_i,
           min_i, decamin_i, hr_i, decahr_i, lap_i,
    input  seg_o, dp_o, digit_sel_o, frame_o, lap_active_o
  );

  // The display scanner itself
  modport slave (
    input  centisec_i, decisec_i, sec_i, decasec_i,
           min_i, decamin_i, hr_i, decahr_i, lap_i,
    output seg_o, dp_o, digit_sel_o, frame_o, lap_active_o
  );

endinterface

// File: rtl/stopwatch_display_scan_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder, active-high; codes above 9 give a dash.
module bcd_to_seg7
  import stopwatch_display_scan_pkg::*;
(
  input  bcd_t  bcd_i,
  output seg7_t seg_o
);

  // Pattern lookup with dash as the fallback for invalid codes
  always_comb begin
    seg_o = SEG7_DASH;
    case (bcd_i)
      4'd0: seg_o = SEG7_0;
      4'd1: seg_o = SEG7_1;
      4'd2: seg_o = SEG7_2;
      4'd3: seg_o = SEG7_3;
      4'd4: seg_o = SEG7_4;
      4'd5: seg_o = SEG7_5;
      4'd6: seg_o = SEG7_6;
      4'd7: seg_o = SEG7_7;
      4'd8: seg_o = SEG7_8;
      4'd9: seg_o = SEG7_9;
      default: seg_o = SEG7_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Multiplexed 8-digit display stage: per-frame snapshot of the stopwatch
// digits, lap freeze, leading-zero blanking, separators and anti-ghost guard.
module stopwatch_display_scan
  import stopwatch_display_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned GUARD          = 2,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned DIG_ACTIVE_LOW = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  stopwatch_display_scan_if.slave  bus
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  typedef logic [PW-1:0] presc_t;

  localparam presc_t PRESC_LAST = presc_t'(SCAN_DIV - 1);
  localparam presc_t GUARD_LIM  = presc_t'(GUARD);
  localparam logic   SEG_INV    = (SEG_ACTIVE_LOW != 0);
  localparam logic   DIG_INV    = (DIG_ACTIVE_LOW != 0);

  // Scan timing
  presc_t      presc_q, presc_d;
  logic [2:0]  idx_q, idx_d;
  logic        tick;
  logic        boundary;

  // Lap handling
  logic        lap_prev_q, lap_prev_d;
  logic        frozen_q, frozen_d;
  logic        lap_rise;

  // Snapshot
  logic [31:0] snap_q, snap_d;
  logic [31:0] live;
  logic        load;

  // Per-slot display data
  logic [7:0]  blank;
  logic        zero_run;
  bcd_t        cur_digit;
  seg7_t       cur_pat;
  logic        cur_dp;
  dig_sel_t    cur_sel;

  // Output registers, stored already in pin polarity
  seg7_t       seg_q, seg_d;
  logic        dp_q, dp_d;
  dig_sel_t    sel_q, sel_d;
  logic        frame_q, frame_d;

  assign live = {bus.decahr_i, bus.hr_i, bus.decamin_i, bus.min_i,
                 bus.decasec_i, bus.sec_i, bus.decisec_i, bus.centisec_i};

  // Prescaler and slot index; the frame ends on the last tick of slot 7
  always_comb begin
    tick     = (presc_q == PRESC_LAST);
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    boundary = tick && (idx_q == 3'(DIG_DECAHR));
  end

  // Lap edge toggles freeze; the load decision uses the post-toggle state so
  // a freeze edge on the boundary cycle already suppresses that load
  always_comb begin
    lap_rise   = bus.lap_i && !lap_prev_q;
    lap_prev_d = bus.lap_i;
    frozen_d   = frozen_q ^ lap_rise;
    load       = boundary && !frozen_d;
    snap_d     = load ? live : snap_q;
    frame_d    = load;
  end

  // Leading-zero blanking from the snapshot: a digit is dark while every
  // digit to its left (inclusive) is zero, down to the decasec position
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= BLANK_LOW; i--) begin
      zero_run = zero_run && (snap_q[4*i +: 4] == 4'd0);
      blank[i] = zero_run;
    end
  end

  // Digit selected by the current slot
  always_comb begin
    cur_digit = snap_q[{idx_q, 2'b00} +: 4];
    cur_dp    = has_dp(idx_q) && !blank[idx_q];
    cur_sel   = (presc_q < GUARD_LIM) ? '0 : digit_onehot(idx_q);
  end

  bcd_to_seg7 u_dec (
    .bcd_i (cur_digit),
    .seg_o (cur_pat)
  );

  // Next output values with pin polarity applied
  always_comb begin
    seg_d = (blank[idx_q] ? SEG7_OFF : cur_pat) ^ {7{SEG_INV}};
    dp_d  = cur_dp ^ SEG_INV;
    sel_d = cur_sel ^ {8{DIG_INV}};
  end

  // State and output registers with synchronous reset to the dark display
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc_q    <= '0;
      idx_q      <= '0;
      snap_q     <= '0;
      frozen_q   <= 1'b0;
      lap_prev_q <= 1'b1;
      seg_q      <= {7{SEG_INV}};
      dp_q       <= SEG_INV;
      sel_q      <= {8{DIG_INV}};
      frame_q    <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      snap_q     <= snap_d;
      frozen_q   <= frozen_d;
      lap_prev_q <= lap_prev_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      sel_q      <= sel_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.seg_o        = seg_q;
  assign bus.dp_o         = dp_q;
  assign bus.digit_sel_o  = sel_q;
  assign bus.frame_o      = frame_q;
  assign bus.lap_active_o = frozen_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Directed bench for the stopwatch display scanner (SCAN_DIV=4, GUARD=1,
// active-low segments and digit enables).
module tb_stopwatch_display_scan;

  logic clk;
  logic reset_i;
  int   checks   = 0;
  int   failures = 0;

  stopwatch_display_scan_if bus ();

  stopwatch_display_scan #(
    .SCAN_DIV       (4),
    .GUARD          (1),
    .SEG_ACTIVE_LOW (1),
    .DIG_ACTIVE_LOW (1)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // Hand-written active-high patterns {g,f,e,d,c,b,a}
  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [31:0] v);
    bus.centisec_i = v[3:0];
    bus.decisec_i  = v[7:4];
    bus.sec_i      = v[11:8];
    bus.decasec_i  = v[15:12];
    bus.min_i      = v[19:16];
    bus.decamin_i  = v[23:20];
    bus.hr_i       = v[27:24];
    bus.decahr_i   = v[31:28];
  endtask

  task automatic wait_frame(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (bus.frame_o === 1'b1) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  // Called on the sample where frame_o pulses; checks the 32 cycles that follow
  task automatic check_frame(input string tag, input logic [31:0] digits,
                             input logic [7:0] blank, input logic [7:0] dpm,
                             input bit do_mid, input logic [31:0] mid_val);
    logic [3:0] d;
    logic [6:0] es;
    logic [7:0] esel;
    for (int s = 0; s < 8; s++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        if (do_mid && s == 3 && c == 0) set_inputs(mid_val);
        d    = digits[4*s +: 4];
        es   = blank[s] ? 7'h7F : ~pat(d);
        esel = (c == 0) ? 8'hFF : ~(8'h01 << s);
        chk($sformatf("%s_sel%0d_%0d", tag, s, c), 32'(bus.digit_sel_o), 32'(esel));
        chk($sformatf("%s_seg%0d_%0d", tag, s, c), 32'(bus.seg_o), 32'(es));
        chk($sformatf("%s_dp%0d_%0d", tag, s, c), 32'(bus.dp_o), dpm[s] ? 32'd0 : 32'd1);
        if (s == 0 && c == 0) chk({tag, "_frame_once"}, 32'(bus.frame_o), 32'd0);
      end
    end
  endtask

  int nframes;

  initial begin
    reset_i  = 1'b1;
    bus.lap_i = 1'b0;
    set_inputs(32'h12345678);

    // 1: reset state, then first load and full scan
    repeat (3) step();
    chk("rst_sel",   32'(bus.digit_sel_o),  32'hFF);
    chk("rst_seg",   32'(bus.seg_o),        32'h7F);
    chk("rst_dp",    32'(bus.dp_o),         32'd1);
    chk("rst_frame", 32'(bus.frame_o),      32'd0);
    chk("rst_lap",   32'(bus.lap_active_o), 32'd0);
    reset_i = 1'b0;
    wait_frame("t1_frame");
    check_frame("t1", 32'h12345678, 8'h00, 8'h54, 1'b0, '0);

    // 2: leading-zero blanking
    set_inputs(32'h00000507);
    wait_frame("t2_frame");
    check_frame("t2", 32'h00000507, 8'hF8, 8'h04, 1'b0, '0);

    // 3: input change mid-frame is not shown until the next frame
    set_inputs(32'h00000100);
    wait_frame("t3_frame");
    check_frame("t3a", 32'h00000100, 8'hF8, 8'h04, 1'b1, 32'h00000200);
    chk("t3_frame2", 32'(bus.frame_o), 32'd1);
    check_frame("t3b", 32'h00000200, 8'hF8, 8'h04, 1'b0, '0);

    // 4: lap freeze holds the display while inputs keep moving
    bus.lap_i = 1'b1;
    step();
    chk("t4_lap_on", 32'(bus.lap_active_o), 32'd1);
    nframes = 0;
    for (int i = 0; i < 95; i++) begin
      if (i == 5) bus.lap_i = 1'b0;
      set_inputs(32'h00000300 + 32'(i));
      step();
      if (bus.frame_o === 1'b1) nframes++;
    end
    chk("t4_noframe", 32'(nframes), 32'd0);
    check_frame("t4_hold", 32'h00000200, 8'hF8, 8'h04, 1'b0, '0);
    chk("t4_noframe_end", 32'(bus.frame_o), 32'd0);
    chk("t4_still_on", 32'(bus.lap_active_o), 32'd1);
    set_inputs(32'h00000333);
    bus.lap_i = 1'b1;
    step();
    chk("t4_lap_off", 32'(bus.lap_active_o), 32'd0);
    wait_frame("t4_reload");
    check_frame("t4_live", 32'h00000333, 8'hF8, 8'h04, 1'b0, '0);

    // 5: freeze edge exactly on the boundary cycle suppresses the load
    bus.lap_i = 1'b0;
    set_inputs(32'h44444444);
    repeat (31) step();
    bus.lap_i = 1'b1;
    step();
    chk("t5_noload", 32'(bus.frame_o), 32'd0);
    chk("t5_lap_on", 32'(bus.lap_active_o), 32'd1);
    check_frame("t5_hold", 32'h00000333, 8'hF8, 8'h04, 1'b0, '0);
    bus.lap_i = 1'b0;
    step();
    bus.lap_i = 1'b1;
    step();
    chk("t5_lap_off", 32'(bus.lap_active_o), 32'd0);
    set_inputs(32'hC0000000);
    wait_frame("t5_reload");
    check_frame("t5_dash", 32'hC0000000, 8'h00, 8'h54, 1'b0, '0);

    // 6: reset mid-slot darkens everything on the next cycle
    bus.lap_i = 1'b0;
    step();
    bus.lap_i = 1'b1;
    step();
    chk("t6_lap_on", 32'(bus.lap_active_o), 32'd1);
    repeat (3) step();
    reset_i = 1'b1;
    step();
    chk("t6_sel",   32'(bus.digit_sel_o),  32'hFF);
    chk("t6_seg",   32'(bus.seg_o),        32'h7F);
    chk("t6_dp",    32'(bus.dp_o),         32'd1);
    chk("t6_frame", 32'(bus.frame_o),      32'd0);
    chk("t6_lap",   32'(bus.lap_active_o), 32'd0);
    reset_i = 1'b0;
    repeat (3) step();
    chk("t6_lap_held", 32'(bus.lap_active_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
